// File: rtl/stopwatch_bcd_pkg.sv
// Shared definitions for the MM:SS BCD stopwatch: run-state encoding and BCD digit limits.
package stopwatch_bcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_t;

   localparam int BCD_W    = 4;
   localparam int N_DIGITS = 4;

   localparam logic [BCD_W-1:0] DIGIT_MAX_ONES = 4'd9;
   localparam logic [BCD_W-1:0] DIGIT_MAX_TENS = 4'd5;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit counter that rolls over at MAX; carry is high while inc is applied at MAX.
module bcd_digit_cnt
   import stopwatch_bcd_pkg::*;
#(
   parameter logic [BCD_W-1:0] MAX = DIGIT_MAX_ONES
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             i_inc,
   input  logic             i_clr,
   output logic [BCD_W-1:0] o_value,
   output logic             o_carry
);

   logic [BCD_W-1:0] r_value;

   always_ff @(posedge clk) begin
      if (rst || i_clr) begin
         r_value <= '0;
      end else if (i_inc) begin
         r_value <= (r_value == MAX) ? '0 : r_value + 1'b1;
      end
   end

   assign o_value = r_value;
   assign o_carry = i_inc & (r_value == MAX);

endmodule

// File: rtl/stopwatch_bcd.sv
// MM:SS BCD stopwatch driven by a synchronised, edge-detected slow clock.
// Optional lap freeze of the displayed value is built when STOPWATCH_LAP_EN is defined.
module stopwatch_bcd
   import stopwatch_bcd_pkg::*;
#(
   parameter int TICKS_PER_SEC = 50,
   parameter int MIN_MAX       = 59
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        slow_clk,
   input  logic        start_stop,
   input  logic        clear,
   input  logic        lap,
   output logic [15:0] digits,
   output logic        running,
   output logic        wrap,
   output logic        lap_hold
);

   localparam int PRE_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(TICKS_PER_SEC - 1);
   localparam logic [BCD_W-1:0] MIN_TENS_MAX = BCD_W'(MIN_MAX / 10);
   localparam logic [BCD_W-1:0] MIN_ONES_CAP = BCD_W'(MIN_MAX % 10);
   localparam logic [N_DIGITS-1:0][BCD_W-1:0] DIGIT_MAX =
      {MIN_TENS_MAX, DIGIT_MAX_ONES, DIGIT_MAX_TENS, DIGIT_MAX_ONES};

   logic                           r_s1, r_s2, r_s3;
   logic                           w_tick;
   state_t                         r_state, w_state_next;
   logic [PRE_W-1:0]               r_pre;
   logic                           w_tick_run, w_sec_step;
   logic [N_DIGITS-1:0][BCD_W-1:0] w_val;
   logic                           w_at_max, w_roll, w_clr;
   logic                           r_wrap;

   // slow_clk is data: three flops give two for metastability plus one for edge detect
   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
         r_s3 <= 1'b0;
      end else begin
         r_s1 <= slow_clk;
         r_s2 <= r_s1;
         r_s3 <= r_s2;
      end
   end

   assign w_tick = r_s2 & ~r_s3;

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      if (clear) begin
         w_state_next = ST_IDLE;
      end else if (start_stop) begin
         case (r_state)
            ST_IDLE:  w_state_next = ST_RUN;
            ST_RUN:   w_state_next = ST_PAUSE;
            ST_PAUSE: w_state_next = ST_RUN;
            default:  w_state_next = ST_IDLE;
         endcase
      end
   end

   // clear and start_stop both swallow a coincident tick
   assign w_tick_run = (r_state == ST_RUN) & w_tick & ~clear & ~start_stop;
   assign w_sec_step = w_tick_run & (r_pre == PRE_LAST);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_pre <= '0;
      end else if (w_tick_run) begin
         r_pre <= (r_pre == PRE_LAST) ? '0 : r_pre + 1'b1;
      end
   end

   genvar gi;
   for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
      logic w_inc;
      logic w_carry;
      if (gi == 0) begin : g_first
         assign w_inc = w_sec_step;
      end else begin : g_chain
         assign w_inc = g_digit[gi-1].w_carry;
      end
      bcd_digit_cnt #(
         .MAX (DIGIT_MAX[gi])
      ) u_digit (
         .clk     (clk),
         .rst     (rst),
         .i_inc   (w_inc),
         .i_clr   (w_clr),
         .o_value (w_val[gi]),
         .o_carry (w_carry)
      );
   end

   // Minute cap need not be x9, so detect the full MM:SS maximum explicitly
   assign w_at_max = (w_val[3] == MIN_TENS_MAX) && (w_val[2] == MIN_ONES_CAP) &&
                     (w_val[1] == DIGIT_MAX_TENS) && (w_val[0] == DIGIT_MAX_ONES);
   assign w_roll   = (w_sec_step & w_at_max) | g_digit[N_DIGITS-1].w_carry;
   assign w_clr    = clear | w_roll;

   always_ff @(posedge clk) begin
      if (rst) r_wrap <= 1'b0;
      else     r_wrap <= w_roll;
   end

   assign running = (r_state == ST_RUN);
   assign wrap    = r_wrap;

`ifdef STOPWATCH_LAP_EN
   logic        r_lap_hold;
   logic [15:0] r_lap_digits;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_lap_hold   <= 1'b0;
         r_lap_digits <= '0;
      end else if (clear) begin
         r_lap_hold <= 1'b0;
      end else if (lap && (r_state != ST_IDLE)) begin
         r_lap_hold <= ~r_lap_hold;
         if (!r_lap_hold) r_lap_digits <= w_val;
      end
   end

   assign digits   = r_lap_hold ? r_lap_digits : w_val;
   assign lap_hold = r_lap_hold;
`else
   logic w_lap_unused;
   assign w_lap_unused = lap;
   assign digits       = w_val;
   assign lap_hold     = 1'b0;
`endif

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Self-checking bench for stopwatch_bcd against a seconds-based reference model.
module tb_stopwatch_bcd;

   localparam int TPS     = 2;
   localparam int MIN_MAX = 59;
   localparam int TOTAL   = (MIN_MAX + 1) * 60;

`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   localparam logic [1:0] M_IDLE  = 2'd0;
   localparam logic [1:0] M_RUN   = 2'd1;
   localparam logic [1:0] M_PAUSE = 2'd2;

   logic        clk = 1'b0;
   logic        rst, slow_clk, start_stop, clear, lap;
   logic [15:0] digits;
   logic        running, wrap, lap_hold;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   stopwatch_bcd #(
      .TICKS_PER_SEC (TPS),
      .MIN_MAX       (MIN_MAX)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .slow_clk   (slow_clk),
      .start_stop (start_stop),
      .clear      (clear),
      .lap        (lap),
      .digits     (digits),
      .running    (running),
      .wrap       (wrap),
      .lap_hold   (lap_hold)
   );

   // Reference model: elapsed whole seconds plus ticks into the current second
   typedef struct packed {
      int         sec;
      int         pre;
      logic [1:0] st;
      logic       wrap;
      logic       hold;
      int         lap_sec;
   } model_t;

   model_t     m;
   logic [2:0] hist;
   wire        m_tick = hist[1] & ~hist[2];

   function automatic model_t model_next(model_t c, logic tk, logic r, logic clr, logic ss, logic lp);
      model_t n = c;
      n.wrap = 1'b0;
      if (r) begin
         n.sec = 0; n.pre = 0; n.st = M_IDLE; n.hold = 1'b0; n.lap_sec = 0;
      end else if (clr) begin
         n.sec = 0; n.pre = 0; n.st = M_IDLE; n.hold = 1'b0;
      end else begin
         if (LAP_EN && lp && c.st != M_IDLE) begin
            n.hold = !c.hold;
            if (!c.hold) n.lap_sec = c.sec;
         end
         if (ss) begin
            n.st = (c.st == M_RUN) ? M_PAUSE : M_RUN;
         end else if (c.st == M_RUN && tk) begin
            if (c.pre == TPS - 1) begin
               n.pre = 0;
               if (c.sec == TOTAL - 1) begin
                  n.sec  = 0;
                  n.wrap = 1'b1;
               end else begin
                  n.sec = c.sec + 1;
               end
            end else begin
               n.pre = c.pre + 1;
            end
         end
      end
      return n;
   endfunction

   function automatic logic [15:0] bcd(int s);
      int mm = s / 60;
      int ss = s % 60;
      return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
   endfunction

   function automatic logic [15:0] exp_digits(model_t c);
      return c.hold ? bcd(c.lap_sec) : bcd(c.sec);
   endfunction

   always @(posedge clk) begin
      m    <= model_next(m, m_tick, rst, clear, start_stop, lap);
      hist <= rst ? 3'b000 : {hist[1:0], slow_clk};
   end

   // ---------------- stimulus helpers (no checking) ----------------
   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic pulse_ss();
      start_stop = 1'b1; @(negedge clk); start_stop = 1'b0;
   endtask

   task automatic pulse_clr();
      clear = 1'b1; @(negedge clk); clear = 1'b0;
   endtask

   task automatic pulse_lap();
      lap = 1'b1; @(negedge clk); lap = 1'b0;
   endtask

   task automatic slow_pulse(input int h, input int l);
      slow_clk = 1'b1; cyc(h);
      slow_clk = 1'b0; cyc(l);
   endtask

   task automatic run_to(input logic [15:0] target, input int budget, input bit fast, output bit ok);
      int g = 0;
      while (digits !== target && g < budget) begin
         if (fast) slow_pulse(3, 3);
         else      slow_pulse($urandom_range(3, 5), $urandom_range(3, 5));
         g++;
      end
      ok = (digits === target);
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      bit ok;
      rst = 1'b1; slow_clk = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0;
      cyc(3);
      rst = 1'b0;
      cyc(1);
      n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL reset_digits: got %h want %h", digits, 16'h0000); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_running: got %b want 0", running); end
      n_cmp++; if (wrap !== 1'b0) begin n_bad++; $display("FAIL reset_wrap: got %b want 0", wrap); end
      n_cmp++; if (lap_hold !== 1'b0) begin n_bad++; $display("FAIL reset_lap_hold: got %b want 0", lap_hold); end

      pulse_ss();
      run_to(16'h0007, 40, 1'b0, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL reset_reach_0007: got %h want %h", digits, 16'h0007); end
      slow_clk = 1'b1;
      rst = 1'b1; cyc(3); rst = 1'b0;
      n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL reset_mid_digits: got %h want %h", digits, 16'h0000); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_mid_running: got %b want 0", running); end
      slow_clk = 1'b0; cyc(3);
      slow_pulse(3, 3); slow_pulse(3, 3); slow_pulse(3, 3);
      n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL reset_idle_ignores_tick: got %h want %h", digits, 16'h0000); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL reset_idle_state: got %b want 0", running); end
      $display("test_reset: digits=%h running=%0d", digits, running);
   endtask

   task automatic test_basic();
      pulse_ss();
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL basic_start_running: got %b want 1", running); end
      for (int p = 0; p < 20; p++) begin
         int h = $urandom_range(3, 5);
         int l = $urandom_range(3, 5);
         slow_clk = 1'b1;
         for (int c = 0; c < h + l; c++) begin
            if (c == h) slow_clk = 1'b0;
            @(negedge clk);
            n_cmp++;
            if (digits !== exp_digits(m)) begin
               n_bad++;
               $display("FAIL basic_cycle p%0d c%0d: got %h want %h", p, c, digits, exp_digits(m));
            end
         end
      end
      n_cmp++; if (digits !== 16'h0010) begin n_bad++; $display("FAIL basic_20_edges: got %h want %h", digits, 16'h0010); end
      $display("test_basic: digits=%h after 20 slow edges", digits);
   endtask

   task automatic test_pause_resume();
      pulse_clr();
      pulse_ss();
      repeat (3) slow_pulse($urandom_range(3, 5), $urandom_range(3, 5));
      n_cmp++; if (digits !== 16'h0001) begin n_bad++; $display("FAIL pause_3_ticks: got %h want %h", digits, 16'h0001); end
      pulse_ss();
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL pause_running: got %b want 0", running); end
      repeat (10) slow_pulse($urandom_range(3, 5), $urandom_range(3, 5));
      n_cmp++; if (digits !== 16'h0001) begin n_bad++; $display("FAIL pause_frozen: got %h want %h", digits, 16'h0001); end
      pulse_ss();
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL resume_running: got %b want 1", running); end
      slow_pulse($urandom_range(3, 5), $urandom_range(3, 5));
      n_cmp++; if (digits !== 16'h0002) begin n_bad++; $display("FAIL resume_partial_kept: got %h want %h", digits, 16'h0002); end
      n_cmp++; if (digits !== exp_digits(m)) begin n_bad++; $display("FAIL resume_model: got %h want %h", digits, exp_digits(m)); end
      $display("test_pause_resume: digits=%h", digits);
   endtask

   task automatic test_simultaneous();
      bit ok;
      int g;
      int wseen;
      pulse_clr();
      pulse_ss();
      run_to(16'h0001, 10, 1'b0, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL simul_reach_0001: got %h want %h", digits, 16'h0001); end
      slow_pulse(3, 3);
      slow_clk = 1'b1; g = 0;
      while (!m_tick && g < 10) begin @(negedge clk); g++; end
      n_cmp++; if (g >= 10) begin n_bad++; $display("FAIL simul_clear_tick_timeout: got %0d cycles want <10", g); end
      clear = 1'b1; @(negedge clk); clear = 1'b0;
      wseen = 0;
      for (int c = 0; c < 4; c++) begin
         if (wrap === 1'b1) wseen++;
         if (c == 2) slow_clk = 1'b0;
         @(negedge clk);
      end
      n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL simul_clear_digits: got %h want %h", digits, 16'h0000); end
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL simul_clear_idle: got %b want 0", running); end
      n_cmp++; if (wseen !== 0) begin n_bad++; $display("FAIL simul_clear_no_wrap: got %0d want 0", wseen); end

      pulse_ss();
      slow_pulse(3, 3);
      slow_clk = 1'b1; g = 0;
      while (!m_tick && g < 10) begin @(negedge clk); g++; end
      n_cmp++; if (g >= 10) begin n_bad++; $display("FAIL simul_ss_tick_timeout: got %0d cycles want <10", g); end
      start_stop = 1'b1; @(negedge clk); start_stop = 1'b0;
      cyc(2); slow_clk = 1'b0; cyc(3);
      n_cmp++; if (running !== 1'b0) begin n_bad++; $display("FAIL simul_ss_pause: got %b want 0", running); end
      n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL simul_ss_no_inc: got %h want %h", digits, 16'h0000); end
      pulse_ss();
      slow_pulse(3, 3);
      n_cmp++; if (digits !== 16'h0001) begin n_bad++; $display("FAIL simul_ss_resume: got %h want %h", digits, 16'h0001); end
      $display("test_simultaneous: digits=%h running=%0d", digits, running);
   endtask

   task automatic test_wrap();
      bit ok;
      int wc = 0;
      pulse_clr();
      pulse_ss();
      run_to(16'h5959, 7300, 1'b1, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL wrap_reach_5959: got %h want %h", digits, 16'h5959); end
      for (int p = 0; p < 2; p++) begin
         slow_clk = 1'b1;
         for (int c = 0; c < 6; c++) begin
            if (c == 3) slow_clk = 1'b0;
            @(negedge clk);
            if (wrap === 1'b1) wc++;
            n_cmp++;
            if (wrap !== m.wrap) begin n_bad++; $display("FAIL wrap_cycle p%0d c%0d: got %b want %b", p, c, wrap, m.wrap); end
         end
      end
      n_cmp++; if (wc !== 1) begin n_bad++; $display("FAIL wrap_one_cycle: got %0d cycles want 1", wc); end
      n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL wrap_digits: got %h want %h", digits, 16'h0000); end
      n_cmp++; if (running !== 1'b1) begin n_bad++; $display("FAIL wrap_running: got %b want 1", running); end
      $display("test_wrap: digits=%h wrap_cycles=%0d", digits, wc);
   endtask

   task automatic test_lap();
      bit ok;
      pulse_clr();
      pulse_lap();
      n_cmp++; if (lap_hold !== 1'b0) begin n_bad++; $display("FAIL lap_idle_ignored: got %b want 0", lap_hold); end
      pulse_ss();
      run_to(16'h0005, 40, 1'b0, ok);
      n_cmp++; if (!ok) begin n_bad++; $display("FAIL lap_reach_0005: got %h want %h", digits, 16'h0005); end
      pulse_lap();
      n_cmp++; if (lap_hold !== LAP_EN) begin n_bad++; $display("FAIL lap_hold_set: got %b want %b", lap_hold, LAP_EN); end
      n_cmp++; if (digits !== 16'h0005) begin n_bad++; $display("FAIL lap_snapshot: got %h want %h", digits, 16'h0005); end
      repeat (12) slow_pulse($urandom_range(3, 5), $urandom_range(3, 5));
`ifdef STOPWATCH_LAP_EN
      n_cmp++; if (digits !== 16'h0005) begin n_bad++; $display("FAIL lap_frozen: got %h want %h", digits, 16'h0005); end
      n_cmp++; if (lap_hold !== 1'b1) begin n_bad++; $display("FAIL lap_hold_kept: got %b want 1", lap_hold); end
`else
      n_cmp++; if (digits !== 16'h0011) begin n_bad++; $display("FAIL lap_off_live: got %h want %h", digits, 16'h0011); end
      n_cmp++; if (lap_hold !== 1'b0) begin n_bad++; $display("FAIL lap_off_hold: got %b want 0", lap_hold); end
`endif
      pulse_lap();
      n_cmp++; if (digits !== 16'h0011) begin n_bad++; $display("FAIL lap_release_digits: got %h want %h", digits, 16'h0011); end
      n_cmp++; if (lap_hold !== 1'b0) begin n_bad++; $display("FAIL lap_release_hold: got %b want 0", lap_hold); end
      n_cmp++; if (digits !== exp_digits(m)) begin n_bad++; $display("FAIL lap_model: got %h want %h", digits, exp_digits(m)); end
      $display("test_lap: lap_en=%0d digits=%h lap_hold=%0d", LAP_EN, digits, lap_hold);
   endtask

   task automatic test_random();
      int sc = 3;
      pulse_clr();
      for (int c = 0; c < 2000; c++) begin
         @(negedge clk);
         n_cmp++; if (digits !== exp_digits(m)) begin n_bad++; $display("FAIL rand_digits c%0d: got %h want %h", c, digits, exp_digits(m)); end
         n_cmp++; if (running !== (m.st == M_RUN)) begin n_bad++; $display("FAIL rand_running c%0d: got %b want %b", c, running, (m.st == M_RUN)); end
         n_cmp++; if (wrap !== m.wrap) begin n_bad++; $display("FAIL rand_wrap c%0d: got %b want %b", c, wrap, m.wrap); end
         n_cmp++; if (lap_hold !== m.hold) begin n_bad++; $display("FAIL rand_lap_hold c%0d: got %b want %b", c, lap_hold, m.hold); end
         rst        = ($urandom_range(0, 599) == 0);
         start_stop = ($urandom_range(0, 29) == 0);
         clear      = ($urandom_range(0, 249) == 0);
         lap        = ($urandom_range(0, 49) == 0);
         if (sc == 0) begin
            slow_clk = ~slow_clk;
            sc = $urandom_range(3, 6);
         end else begin
            sc--;
         end
      end
      rst = 1'b0; start_stop = 1'b0; clear = 1'b0; lap = 1'b0; slow_clk = 1'b0;
      cyc(4);
      $display("test_random: digits=%h running=%0d", digits, running);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_basic();
      test_pause_resume();
      test_simultaneous();
      test_lap();
      test_wrap();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/stopwatch_bcd.md
# stopwatch_bcd

Minutes/seconds stopwatch that consumes the slow square-wave output of the clock divider and turns it into a 4-digit BCD count (MM:SS). The divided clock is never used as a clock: it is synchronised into the system clock domain and edge-detected to form a one-cycle tick. Outputs drive the 7-segment scan stage downstream.

## Interface
- `TICKS_PER_SEC`, default 50: slow-clock rising edges per counted second (50 Hz divider output at 50 MHz).
- `MIN_MAX`, default 59: highest minute value before wrap.
- `clk` input 1: system clock; all logic on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `slow_clk` input 1: divided clock from the divider; asynchronous to logic sampling, treated as data.
- `start_stop` input 1: one-cycle pulse; toggles run/pause.
- `clear` input 1: one-cycle pulse; zero count, go idle.
- `lap` input 1: one-cycle pulse; toggles lap hold (only with `STOPWATCH_LAP_EN`).
- `digits` output 16: {min_tens, min_ones, sec_tens, sec_ones}, BCD.
- `running` output 1: high in RUN state.
- `wrap` output 1: one-cycle pulse when count rolls MM:SS max → 00:00.
- `lap_hold` output 1: high while displayed value is frozen.

## Operation
- Reset values: `digits`=16'h0000, `running`=0, `wrap`=0, `lap_hold`=0, prescaler=0, state IDLE, synchroniser flops 0.
- Tick: `slow_clk` → s1 → s2 → s3; `tick` = s2 & ~s3.
- Prescaler: 0..TICKS_PER_SEC-1, advances on `tick` only in RUN; at TICKS_PER_SEC-1 with tick → 0 and one-second increment.
- Increment: sec_ones 0–9, sec_tens 0–5, min_ones 0–9, min_tens 0–(MIN_MAX/10), cap at MIN_MAX; carries ripple in the same cycle. All digits max + increment → all 0, `wrap` high 1 cycle.
- States: IDLE (count 0, not counting) –start_stop→ RUN; RUN –start_stop→ PAUSE; PAUSE –start_stop→ RUN. `clear` from any state → IDLE.
- PAUSE keeps `digits` and prescaler value; ticks ignored; resume continues partial second.
- Priority, same cycle: `rst` > `clear` > `start_stop` > increment. `clear` with tick: count 0, no increment, no `wrap`. `start_stop` with tick in RUN: enter PAUSE, tick discarded.
- Reset mid-count: next cycle all values per reset list regardless of state.

## Timing
- `slow_clk` high first sampled at edge k: s2 high at k+1, `tick` high during cycle k+1→k+2, prescaler/count update at edge k+2.
- `start_stop`/`clear`: state and `running` update on the edge sampling the pulse (latency 1).
- `wrap` asserted in the cycle following the rolling edge, exactly one cycle.
- `slow_clk` high time must exceed 2 `clk` periods; shorter pulses may be missed.

## Configuration
- `STOPWATCH_LAP_EN` defined: `lap` pulse snapshots internal count into a lap register, `lap_hold`=1, `digits` shows snapshot while counting continues; next `lap` releases (`lap_hold`=0, `digits` live). `clear` and `rst` release hold. `lap` in IDLE ignored.
- Not defined: no lap register, `lap` ignored, `lap_hold` tied 0, `digits` always live.

## Structure
- Shared package: state encoding (IDLE/RUN/PAUSE), BCD digit width constant (4), digit max constants (9, 5).
- Sub-module `bcd_digit_cnt`: one BCD digit, parameter MAX, inputs inc/clr, outputs value and carry (inc at MAX). Four instances chained.

## Test plan
- Reset: hold `rst` 3 cycles mid-RUN at 00:07 → `digits`=0000, `running`=0, IDLE.
- Basic count (TICKS_PER_SEC=2, slow_clk period 8 clk): start, 20 slow edges → `digits`=0010; count changes exactly at edge k+2 after sampled rise.
- Pause/resume: pause after 3 ticks, 10 ticks while paused → unchanged; resume, 1 tick → +1 s (partial second kept).
- Wrap (MIN_MAX=59): preload path via counting to 59:59, one second → 0000, `wrap` high 1 cycle, `running` stays 1.
- Simultaneous: `clear` on tick cycle at 00:01 → 0000, IDLE, no `wrap`; `start_stop` on tick in RUN → PAUSE, no increment.
- Lap (macro on): `lap` at 00:05, 6 more seconds → `digits`=0005, `lap_hold`=1; `lap` → `digits`=0011, `lap_hold`=0; macro off → `lap` ignored.
